scan_frame_integrity_checker: RTL and testbench

- Downstream consumer of the encrypt-and-serialize stage's 1-bit serial output on the IEEE 1838 scan path.
- Deserializes a 128-bit ciphertext frame followed by a 32-bit CRC signature.
- Recomputes CRC-32 over the received data bits, compares it with the signature, and presents the parallel frame with a pass/fail verdict and running statistics.
- Its parallel output feeds the decrypt side.

---
 rtl/scan_sec_pkg.sv | 27 ++
 rtl/scan_frame_integrity_checker_if.sv | 34 +++
 rtl/scan_crc_serial.sv | 29 ++
 rtl/scan_frame_integrity_checker.sv | 150 +++++++++++++++
 tb/tb_scan_frame_integrity_checker.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/scan_sec_pkg.sv
// Shared types and defaults for the scan-path frame integrity checker.
// Holds the FSM state encoding and the one-bit serial CRC step.
package scan_sec_pkg;

  localparam int                    SCAN_DATA_W = 128;
  localparam int                    SCAN_CRC_W  = 32;
  localparam logic [SCAN_CRC_W-1:0] SCAN_POLY   = 32'h04C11DB7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DATA  = 2'd1,
    ST_SIG   = 2'd2,
    ST_CHECK = 2'd3
  } scan_state_e;

  // MSB-first shift with feedback from the outgoing bit xor the incoming bit.
  function automatic logic [SCAN_CRC_W-1:0] crc_step(
    input logic [SCAN_CRC_W-1:0] crc,
    input logic                  b,
    input logic [SCAN_CRC_W-1:0] poly
  );
    logic fb;
    fb = crc[SCAN_CRC_W-1] ^ b;
    return {crc[SCAN_CRC_W-2:0], 1'b0} ^ (fb ? poly : '0);
  endfunction

endpackage

// File: rtl/scan_frame_integrity_checker_if.sv
// Bundle of the scan-bit input qualifiers and the verdict/statistics outputs.
// Optional tamper_lock signal exists only with SCAN_INTEGRITY_LOCK_EN.
interface scan_frame_integrity_checker_if #(
  parameter int DATA_W = 128,
  parameter int CNT_W  = 16
);
  logic              frame_start;
  logic              serial_in;
  logic              shift_en;
  logic [DATA_W-1:0] frame_data;
  logic              frame_valid;
  logic              crc_ok;
  logic              crc_err;
  logic              busy;
  logic [CNT_W-1:0]  frame_cnt;
  logic [CNT_W-1:0]  err_cnt;
`ifdef SCAN_INTEGRITY_LOCK_EN
  logic              tamper_lock;

  modport master (output frame_start, serial_in, shift_en,
                  input  frame_data, frame_valid, crc_ok, crc_err, busy,
                         frame_cnt, err_cnt, tamper_lock);
  modport slave  (input  frame_start, serial_in, shift_en,
                  output frame_data, frame_valid, crc_ok, crc_err, busy,
                         frame_cnt, err_cnt, tamper_lock);
`else
  modport master (output frame_start, serial_in, shift_en,
                  input  frame_data, frame_valid, crc_ok, crc_err, busy,
                         frame_cnt, err_cnt);
  modport slave  (input  frame_start, serial_in, shift_en,
                  output frame_data, frame_valid, crc_ok, crc_err, busy,
                         frame_cnt, err_cnt);
`endif
endinterface

// File: rtl/scan_crc_serial.sv
// Serial CRC register: seeded on init, advanced one bit per enabled cycle.
module scan_crc_serial
  import scan_sec_pkg::*;
#(
  parameter logic [SCAN_CRC_W-1:0] POLY = SCAN_POLY,
  parameter logic [SCAN_CRC_W-1:0] INIT = 32'hFFFFFFFF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  init,
  input  logic                  step_en,
  input  logic                  bit_in,
  output logic [SCAN_CRC_W-1:0] crc
);
  logic [SCAN_CRC_W-1:0] crc_q, crc_d;

  always_comb begin
    crc_d = crc_q;
    if (init)         crc_d = INIT;
    else if (step_en) crc_d = crc_step(crc_q, bit_in, POLY);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) crc_q <= '0;
    else        crc_q <= crc_d;
  end

  assign crc = crc_q;
endmodule

// File: rtl/scan_frame_integrity_checker.sv
// Deserializes a data frame plus CRC signature from the scan path and reports a verdict.
// Define SCAN_INTEGRITY_LOCK_EN to add a sticky tamper lock that blanks the output.
module scan_frame_integrity_checker
  import scan_sec_pkg::*;
#(
  parameter int                    DATA_W      = SCAN_DATA_W,
  parameter int                    CRC_W       = SCAN_CRC_W,
  parameter logic [SCAN_CRC_W-1:0] POLY        = SCAN_POLY,
  parameter logic [SCAN_CRC_W-1:0] INIT        = 32'hFFFFFFFF,
  parameter int                    CNT_W       = 16,
  parameter int                    LOCK_THRESH = 4
) (
  input logic                          clk,
  input logic                          reset_n,
  scan_frame_integrity_checker_if.slave sif
);
  localparam int BCNT_W = $clog2(DATA_W > CRC_W ? DATA_W : CRC_W);
  localparam logic [BCNT_W-1:0] LAST_D = BCNT_W'(DATA_W - 1);
  localparam logic [BCNT_W-1:0] LAST_S = BCNT_W'(CRC_W - 1);

  scan_state_e       state_q, state_d;
  logic [BCNT_W-1:0] bcnt_q, bcnt_d;
  logic [DATA_W-1:0] data_q, data_d, fdata_q, fdata_d;
  logic [CRC_W-1:0]  sig_q, sig_d, sig_next;
  logic              fvalid_q, fvalid_d, ok_q, ok_d, err_q, err_d;
  logic [CNT_W-1:0]  fcnt_q, fcnt_d, ecnt_q, ecnt_d;
  logic              crc_init, crc_en, match;
  logic [CRC_W-1:0]  crc;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  scan_crc_serial #(.POLY(POLY), .INIT(INIT)) u_crc (
    .clk    (clk),
    .rst_n  (reset_n),
    .init   (crc_init),
    .step_en(crc_en),
    .bit_in (sif.serial_in),
    .crc    (crc)
  );

  assign sig_next = {sig_q[CRC_W-2:0], sif.serial_in};
  assign match    = (sig_next == crc);

  always_comb begin
    state_d  = state_q;
    bcnt_d   = bcnt_q;
    data_d   = data_q;
    sig_d    = sig_q;
    fdata_d  = fdata_q;
    fvalid_d = 1'b0;
    ok_d     = ok_q;
    err_d    = err_q;
    fcnt_d   = fcnt_q;
    ecnt_d   = ecnt_q;
    crc_init = 1'b0;
    crc_en   = 1'b0;
    // A start always wins over a coincident bit; mid-frame it counts as an abort.
    if (sif.frame_start) begin
      if (state_q == ST_DATA || state_q == ST_SIG) ecnt_d = sat_inc(ecnt_q);
      state_d  = ST_DATA;
      bcnt_d   = '0;
      data_d   = '0;
      sig_d    = '0;
      crc_init = 1'b1;
    end else begin
      case (state_q)
        ST_DATA: if (sif.shift_en) begin
          data_d = {data_q[DATA_W-2:0], sif.serial_in};
          crc_en = 1'b1;
          if (bcnt_q == LAST_D) begin
            bcnt_d  = '0;
            state_d = ST_SIG;
          end else begin
            bcnt_d = bcnt_q + 1'b1;
          end
        end
        ST_SIG: if (sif.shift_en) begin
          sig_d = sig_next;
          if (bcnt_q == LAST_S) begin
            // Verdict is registered here so it is visible throughout the CHECK cycle.
            bcnt_d   = '0;
            state_d  = ST_CHECK;
            fdata_d  = data_q;
            fvalid_d = 1'b1;
            ok_d     = match;
            err_d    = !match;
            fcnt_d   = sat_inc(fcnt_q);
            if (!match) ecnt_d = sat_inc(ecnt_q);
          end else begin
            bcnt_d = bcnt_q + 1'b1;
          end
        end
        ST_CHECK: state_d = ST_IDLE;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      bcnt_q   <= '0;
      data_q   <= '0;
      sig_q    <= '0;
      fdata_q  <= '0;
      fvalid_q <= 1'b0;
      ok_q     <= 1'b0;
      err_q    <= 1'b0;
      fcnt_q   <= '0;
      ecnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      bcnt_q   <= bcnt_d;
      data_q   <= data_d;
      sig_q    <= sig_d;
      fdata_q  <= fdata_d;
      fvalid_q <= fvalid_d;
      ok_q     <= ok_d;
      err_q    <= err_d;
      fcnt_q   <= fcnt_d;
      ecnt_q   <= ecnt_d;
    end
  end

  assign sif.crc_ok    = ok_q;
  assign sif.crc_err   = err_q;
  assign sif.busy      = (state_q != ST_IDLE);
  assign sif.frame_cnt = fcnt_q;
  assign sif.err_cnt   = ecnt_q;

`ifdef SCAN_INTEGRITY_LOCK_EN
  logic lock_q, lock_d;

  assign lock_d = lock_q | (ecnt_q >= CNT_W'(LOCK_THRESH));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) lock_q <= 1'b0;
    else          lock_q <= lock_d;
  end

  assign sif.tamper_lock = lock_q;
  assign sif.frame_data  = lock_q ? '0 : fdata_q;
  assign sif.frame_valid = fvalid_q & ~lock_q;
`else
  assign sif.frame_data  = fdata_q;
  assign sif.frame_valid = fvalid_q;
`endif
endmodule

// File: tb/tb_scan_frame_integrity_checker.sv
// Scoreboard bench: expected verdicts are queued as frames are driven and popped on frame_valid.
// A second instance built with INIT=0 covers the all-zero frame case.
module tb_scan_frame_integrity_checker;
  localparam int DATA_W = 128;
  localparam int CNT_W  = 16;
  localparam logic [31:0] POLY = 32'h04C11DB7;
  localparam logic [31:0] SEED = 32'hFFFFFFFF;

  typedef struct {
    logic [DATA_W-1:0] data;
    logic              ok;
    logic [CNT_W-1:0]  fcnt;
    logic [CNT_W-1:0]  ecnt;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  scan_frame_integrity_checker_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) ifa ();
  scan_frame_integrity_checker_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) ifz ();

  scan_frame_integrity_checker #(.INIT(SEED)) u_dut (
    .clk(clk), .reset_n(reset_n), .sif(ifa));
  scan_frame_integrity_checker #(.INIT(32'h0)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .sif(ifz));

  exp_t              sbq[$];
  int                checks = 0;
  int                errors = 0;
  int                busy_drop;
  logic [CNT_W-1:0]  exp_fcnt, exp_ecnt;
  logic [DATA_W-1:0] kdata;
  logic [31:0]       ksig;

  function automatic logic [31:0] model_crc(input logic [DATA_W-1:0] d, input logic [31:0] seed);
    logic [31:0] c;
    logic        fb;
    c = seed;
    for (int i = DATA_W - 1; i >= 0; i--) begin
      fb = c[31] ^ d[i];
      c  = (c << 1) ^ (fb ? POLY : 32'h0);
    end
    return c;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (reset_n && ifa.frame_valid) begin
      checks++;
      if (sbq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_valid: frame_valid=1 with no verdict expected at %0t", $time);
      end else begin
        e = sbq.pop_front();
        if (ifa.frame_data !== e.data || ifa.crc_ok !== e.ok || ifa.crc_err !== !e.ok ||
            ifa.frame_cnt !== e.fcnt || ifa.err_cnt !== e.ecnt) begin
          errors++;
          $display("FAIL verdict: got data=%h ok=%b err=%b fcnt=%0d ecnt=%0d, expected data=%h ok=%b fcnt=%0d ecnt=%0d",
                   ifa.frame_data, ifa.crc_ok, ifa.crc_err, ifa.frame_cnt, ifa.err_cnt,
                   e.data, e.ok, e.fcnt, e.ecnt);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick();
    tick();
    reset_n  = 1'b1;
    exp_fcnt = '0;
    exp_ecnt = '0;
    sbq.delete();
  endtask

  task automatic start_frame(input logic with_bit);
    ifa.frame_start = 1'b1;
    ifa.shift_en    = with_bit;
    ifa.serial_in   = 1'b1;
    tick();
    ifa.frame_start = 1'b0;
    ifa.shift_en    = 1'b0;
  endtask

  task automatic drive_bit(input logic b, input int maxgap);
    int gap;
    gap = (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0;
    repeat (gap) begin
      ifa.shift_en = 1'b0;
      tick();
      if (ifa.busy !== 1'b1) busy_drop++;
    end
    ifa.shift_en  = 1'b1;
    ifa.serial_in = b;
    tick();
    ifa.shift_en  = 1'b0;
    if (ifa.busy !== 1'b1) busy_drop++;
  endtask

  task automatic send_frame(input logic [DATA_W-1:0] d, input logic [31:0] s,
                            input int maxgap, input logic visible, input logic start_bit);
    exp_t e;
    logic ok;
    ok = (s == model_crc(d, SEED));
    if (exp_fcnt != '1) exp_fcnt++;
    if (!ok && exp_ecnt != '1) exp_ecnt++;
    e.data = d; e.ok = ok; e.fcnt = exp_fcnt; e.ecnt = exp_ecnt;
    if (visible) sbq.push_back(e);
    busy_drop = 0;
    start_frame(start_bit);
    for (int i = DATA_W - 1; i >= 0; i--) drive_bit(d[i], maxgap);
    for (int i = 31; i >= 0; i--) drive_bit(s[i], maxgap);
  endtask

  task automatic test_reset();
    ifa.frame_start = 0; ifa.shift_en = 0; ifa.serial_in = 0;
    ifz.frame_start = 0; ifz.shift_en = 0; ifz.serial_in = 0;
    do_reset();
    checks++;
    if (ifa.busy !== 0 || ifa.frame_valid !== 0 || ifa.crc_ok !== 0 || ifa.crc_err !== 0 ||
        ifa.frame_cnt !== 0 || ifa.err_cnt !== 0 || ifa.frame_data !== '0) begin
      errors++;
      $display("FAIL reset_state: busy=%b valid=%b ok=%b err=%b fcnt=%0d ecnt=%0d, expected all 0",
               ifa.busy, ifa.frame_valid, ifa.crc_ok, ifa.crc_err, ifa.frame_cnt, ifa.err_cnt);
    end
  endtask

  task automatic test_zero_init();
    ifz.frame_start = 1'b1;
    tick();
    ifz.frame_start = 1'b0;
    ifz.shift_en    = 1'b1;
    ifz.serial_in   = 1'b0;
    repeat (DATA_W + 32) tick();
    ifz.shift_en = 1'b0;
    checks++;
    if (ifz.frame_valid !== 1 || ifz.crc_ok !== 1 || ifz.crc_err !== 0 || ifz.frame_data !== '0 ||
        ifz.frame_cnt !== 1 || ifz.err_cnt !== 0) begin
      errors++;
      $display("FAIL zero_init: valid=%b ok=%b err=%b fcnt=%0d ecnt=%0d, expected 1 1 0 1 0",
               ifz.frame_valid, ifz.crc_ok, ifz.crc_err, ifz.frame_cnt, ifz.err_cnt);
    end
  endtask

  task automatic test_known_frame();
    send_frame(kdata, ksig, 0, 1'b1, 1'b0);
    checks++;
    if (ifa.frame_valid !== 1'b1) begin
      errors++;
      $display("FAIL latency: frame_valid=%b one cycle after last bit, expected 1", ifa.frame_valid);
    end
    send_frame(kdata, ksig ^ 32'h1, 0, 1'b1, 1'b0);
    tick();
    checks++;
    if (ifa.crc_err !== 1 || ifa.crc_ok !== 0 || ifa.err_cnt !== 1 || ifa.frame_valid !== 0) begin
      errors++;
      $display("FAIL bad_sig_hold: err=%b ok=%b ecnt=%0d valid=%b, expected 1 0 1 0",
               ifa.crc_err, ifa.crc_ok, ifa.err_cnt, ifa.frame_valid);
    end
  endtask

  task automatic test_gaps();
    tick();
    send_frame(kdata, ksig, 5, 1'b1, 1'b0);
    checks++;
    if (busy_drop != 0) begin
      errors++;
      $display("FAIL busy_gaps: busy low for %0d cycles during frame, expected 0", busy_drop);
    end
  endtask

  task automatic test_abort();
    do_reset();
    start_frame(1'b0);
    for (int i = DATA_W - 1; i >= DATA_W - 60; i--) drive_bit(kdata[i], 0);
    exp_ecnt++;
    send_frame(kdata, ksig, 0, 1'b1, 1'b0);
    tick();
    checks++;
    if (ifa.frame_cnt !== 1 || ifa.err_cnt !== 1 || ifa.crc_ok !== 1) begin
      errors++;
      $display("FAIL abort_counts: fcnt=%0d ecnt=%0d ok=%b, expected 1 1 1",
               ifa.frame_cnt, ifa.err_cnt, ifa.crc_ok);
    end
  endtask

  task automatic test_back_to_back();
    logic [DATA_W-1:0] d2;
    d2 = {$urandom, $urandom, $urandom, $urandom};
    send_frame(d2, model_crc(d2, SEED), 0, 1'b1, 1'b1);
    send_frame(kdata, ksig, 0, 1'b1, 1'b0);
    send_frame(d2, ~model_crc(d2, SEED), 0, 1'b1, 1'b0);
    tick();
    checks++;
    if (ifa.frame_cnt !== exp_fcnt || ifa.err_cnt !== exp_ecnt) begin
      errors++;
      $display("FAIL back_to_back: fcnt=%0d ecnt=%0d, expected %0d %0d",
               ifa.frame_cnt, ifa.err_cnt, exp_fcnt, exp_ecnt);
    end
  endtask

  task automatic test_reset_mid_sig();
    start_frame(1'b0);
    for (int i = DATA_W - 1; i >= 0; i--) drive_bit(kdata[i], 0);
    for (int i = 31; i >= 22; i--) drive_bit(ksig[i], 0);
    reset_n = 1'b0;
    #1;
    checks++;
    if (ifa.busy !== 0 || ifa.frame_data !== '0 || ifa.crc_ok !== 0 || ifa.crc_err !== 0 ||
        ifa.frame_cnt !== 0 || ifa.err_cnt !== 0 || ifa.frame_valid !== 0) begin
      errors++;
      $display("FAIL reset_mid_sig: busy=%b ok=%b err=%b fcnt=%0d ecnt=%0d, expected all 0",
               ifa.busy, ifa.crc_ok, ifa.crc_err, ifa.frame_cnt, ifa.err_cnt);
    end
    tick();
    reset_n  = 1'b1;
    exp_fcnt = '0;
    exp_ecnt = '0;
    send_frame(kdata, ksig, 0, 1'b1, 1'b0);
    tick();
    checks++;
    if (ifa.frame_cnt !== 1 || ifa.crc_ok !== 1 || ifa.frame_data !== kdata) begin
      errors++;
      $display("FAIL post_reset_frame: fcnt=%0d ok=%b data=%h, expected 1 1 %h",
               ifa.frame_cnt, ifa.crc_ok, ifa.frame_data, kdata);
    end
  endtask

`ifdef SCAN_INTEGRITY_LOCK_EN
  task automatic test_lock();
    do_reset();
    for (int k = 0; k < 4; k++) send_frame(kdata, ksig ^ 32'h80000000, 0, 1'b1, 1'b0);
    tick();
    tick();
    checks++;
    if (ifa.tamper_lock !== 1'b1 || ifa.frame_data !== '0) begin
      errors++;
      $display("FAIL lock_set: tamper_lock=%b data=%h, expected 1 and 0", ifa.tamper_lock, ifa.frame_data);
    end
    send_frame(kdata, ksig, 0, 1'b0, 1'b0);
    checks++;
    if (ifa.frame_valid !== 0 || ifa.frame_data !== '0 || ifa.frame_cnt !== 5 || ifa.err_cnt !== 4) begin
      errors++;
      $display("FAIL lock_gate: valid=%b data=%h fcnt=%0d ecnt=%0d, expected 0 0 5 4",
               ifa.frame_valid, ifa.frame_data, ifa.frame_cnt, ifa.err_cnt);
    end
  endtask
`endif

  initial begin
    kdata = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    ksig  = model_crc(kdata, SEED);
    test_reset();
    test_zero_init();
    test_known_frame();
    test_gaps();
    test_abort();
    test_back_to_back();
    test_reset_mid_sig();
`ifdef SCAN_INTEGRITY_LOCK_EN
    test_lock();
`endif
    repeat (5) tick();
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL pending_verdicts: %0d expected verdicts never seen, expected 0", sbq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
